// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the default NOP encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // FETCH: requesting; HOLD: skid buffer occupied, waiting for stall to drop;
  // HALTED: parked until reset.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. Priority: reset, flush, stall (hold), load, bubble.
module if_id_latch
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  logic  load,
  input  word_t instr_in,
  input  word_t npc_in,
  output word_t instr_out,
  output word_t npc_out,
  output logic  valid_out
);

  word_t instr_q;
  word_t npc_q;
  logic  valid_q;

  // Register update; with neither stall nor load a bubble is inserted and npc is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_WORD;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (stall) begin
      instr_q <= instr_q;
    end else if (load) begin
      instr_q <= instr_in;
      npc_q   <= npc_in;
      valid_q <= 1'b1;
    end else begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end
  end

  assign instr_out = instr_q;
  assign npc_out   = npc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM, one-entry skid buffer and accepted-fetch counter
// feeding the IF/ID register.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  word_t       imem_addr,
  input  word_t       rtn_addr,
  output logic        pc_en,
  output logic        iREN,
  output word_t       imemaddr,
  input  logic        ihit,
  input  word_t       iload,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  output word_t       instr_out,
  output word_t       npc_out,
  output logic        valid_out,
  output logic [15:0] fetch_cnt
);

  fetch_state_t state_q, state_d;
  word_t        buf_instr_q, buf_instr_d;
  word_t        buf_npc_q, buf_npc_d;
  logic [15:0]  cnt_q, cnt_d;

  logic  lat_flush;
  logic  lat_stall;
  logic  lat_load;
  word_t lat_instr;
  word_t lat_npc;

  assign imemaddr  = imem_addr;
  assign fetch_cnt = cnt_q;

  // Next-state, skid buffer capture, IF/ID controls and memory/pc strobes.
  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_npc_d   = buf_npc_q;
    cnt_d       = cnt_q;
    iREN        = 1'b0;
    pc_en       = 1'b0;
    lat_flush   = 1'b0;
    lat_stall   = 1'b1;
    lat_load    = 1'b0;
    lat_instr   = iload;
    lat_npc     = rtn_addr;

    unique case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (flush) begin
          // Redirect: pc loads the target, any word arriving now is dropped.
          pc_en     = 1'b1;
          lat_flush = 1'b1;
        end else if (halt) begin
          state_d = HALTED;
        end else if (ihit) begin
          pc_en = 1'b1;
          if (stall) begin
            buf_instr_d = iload;
            buf_npc_d   = rtn_addr;
            state_d     = HOLD;
          end else begin
            lat_stall = 1'b0;
            lat_load  = 1'b1;
            cnt_d     = cnt_q + 16'd1;
          end
        end else begin
          // No data: hold under stall, otherwise the latch inserts a bubble.
          lat_stall = stall;
        end
      end
      HOLD: begin
        lat_instr = buf_instr_q;
        lat_npc   = buf_npc_q;
        if (flush) begin
          pc_en     = 1'b1;
          lat_flush = 1'b1;
          state_d   = FETCH;
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          lat_stall = 1'b0;
          lat_load  = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (RST) begin
      iREN  = 1'b0;
      pc_en = 1'b0;
    end
  end

  // FSM, skid buffer and counter state; reset drops any buffered word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      buf_instr_q <= '0;
      buf_npc_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_instr_q <= buf_instr_d;
      buf_npc_q   <= buf_npc_d;
      cnt_q       <= cnt_d;
    end
  end

  if_id_latch #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk       (CLK),
    .rst       (RST),
    .flush     (lat_flush),
    .stall     (lat_stall),
    .load      (lat_load),
    .instr_in  (lat_instr),
    .npc_in    (lat_npc),
    .instr_out (instr_out),
    .npc_out   (npc_out),
    .valid_out (valid_out)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter NOP_WORD, default 32'h00000000, instruction word driven into IF/ID when invalid or flushed.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imem_addr  input  word_t  current PC from pc block.
REQ-005 SHALL have port rtn_addr  input  word_t  PC+4 from pc block.
REQ-006 SHALL have port pc_en  output  1  advance/load strobe to pc block.
REQ-007 SHALL have port iREN  output  1  instruction memory read request.
REQ-008 SHALL have port imemaddr  output  word_t  memory address, equal to imem_addr.
REQ-009 SHALL have port ihit  input  1  memory response valid this cycle, data on iload.
REQ-010 SHALL have port iload  input  word_t  fetched instruction.
REQ-011 SHALL have port stall  input  1  downstream hazard hold of IF/ID.
REQ-012 SHALL have port flush  input  1  branch/jump redirect; squash fetched work.
REQ-013 SHALL have port halt  input  1  halt decoded downstream; stop fetching.
REQ-014 SHALL have ports instr_out (word_t), npc_out (word_t), valid_out (1), all outputs, forming the IF/ID register.
REQ-015 SHALL have port fetch_cnt  output  16  count of instructions accepted into IF/ID.

Function
REQ-016 SHALL implement states FETCH, HOLD, HALTED.
REQ-017 FETCH: iREN=1; on ihit & !stall, IF/ID <= {iload, rtn_addr, 1} next edge, pc_en=1 same cycle, stay FETCH.
REQ-018 FETCH: on ihit & stall, iload/rtn_addr captured into one-entry skid buffer, pc_en=1, next state HOLD; IF/ID unchanged.
REQ-019 FETCH without ihit: pc_en=0; IF/ID holds if stall, else valid_out <= 0 and instr_out <= NOP_WORD (bubble).
REQ-020 HOLD: iREN=0, pc_en=0; when stall=0, IF/ID <= buffer contents, valid_out <= 1, next state FETCH.
REQ-021 flush (any state except HALTED) SHALL override stall and ihit: IF/ID <= {NOP_WORD, 0, 0}, buffer cleared, pc_en=1 (pc loads target), next state FETCH, ihit data that cycle discarded.
REQ-022 halt=1 SHALL move to HALTED next edge unless flush is high the same cycle (flush wins); HALTED: iREN=0, pc_en=0, IF/ID holds, exits only on RST.
REQ-023 imemaddr SHALL equal imem_addr combinationally in all states.
REQ-024 fetch_cnt SHALL increment by 1 each edge where valid_out is newly loaded from iload or buffer; wraps 16'hFFFF -> 0.
REQ-025 Latency: ihit in cycle N with no stall -> instr_out valid in cycle N+1.
REQ-026 pc_en SHALL never be high in two consecutive cycles for the same fetched word.

Reset
REQ-027 On RST=1 at edge: state FETCH, valid_out=0, instr_out=NOP_WORD, npc_out=0, buffer empty, fetch_cnt=0.
REQ-028 While RST=1: iREN=0, pc_en=0; RST mid-HOLD or mid-request SHALL discard buffered/pending word.

Structure
REQ-029 fetch state enum (fetch_state_t) and NOP_WORD default SHALL live in cpu_types_pkg; word_t reused from it.
REQ-030 IF/ID register SHALL be a sub-module if_id_latch (stall/flush/load controls); FSM and skid buffer stay in fetch_stage.

Verification
REQ-031 Reset, then ihit=1 iload=32'h8C220004 rtn_addr=4 -> next cycle instr_out=32'h8C220004, npc_out=4, valid_out=1, fetch_cnt=1.
REQ-032 stall=1 with ihit iload=32'h00221820 -> pc_en=1 once, state HOLD, iREN=0; stall drop -> instr_out=32'h00221820 next cycle.
REQ-033 flush=1 with ihit=1 and stall=1 -> valid_out=0, instr_out=NOP_WORD, pc_en=1, state FETCH, fetch_cnt unchanged.
REQ-034 halt=1 -> iREN=0 thereafter for 20 cycles despite ihit pulses; RST=1 -> iREN=1 cycle after release.
REQ-035 65536 accepted fetches -> fetch_cnt wraps to 0.
REQ-036 ihit withheld 5 cycles, stall=0 -> valid_out=0 bubbles, pc_en=0 throughout, iREN=1 steady.
